// File: rtl/buffer_token_reader_if.sv
// ----------------------------------------------------------------------------
// buffer_token_reader_if
//   Bundles the control, buffer and token-stream signals of buffer_token_reader.
//   master : the requester/consumer side (drives start, abort, buffer, tok_ready)
//   slave  : the reader block (drives tok_valid, token, tok_last, busy, done,
//            count)
//   buffer is [0:383]: 96 nibble slots, slot k = bits [4k:4k+3], bit 4k = MSB.
// ----------------------------------------------------------------------------
interface buffer_token_reader_if;
  logic         start;
  logic         abort;
  logic [0:383] buffer;
  logic         tok_ready;
  logic         tok_valid;
  logic [3:0]   token;
  logic         tok_last;
  logic         busy;
  logic         done;
  logic [6:0]   count;

  modport master (
    output start, abort, buffer, tok_ready,
    input  tok_valid, token, tok_last, busy, done, count
  );

  modport slave (
    input  start, abort, buffer, tok_ready,
    output tok_valid, token, tok_last, busy, done, count
  );
endinterface

// File: rtl/buffer_token_reader.sv
// ----------------------------------------------------------------------------
// buffer_token_reader
//   Snapshots a 96-slot nibble display buffer on start and streams its tokens
//   out over a valid/ready handshake, slot 0 first, stopping at the first empty
//   (0xF) slot or after slot 95. A one-cycle done pulse ends each completed
//   readout and count reports how many tokens were transferred.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : buffer_token_reader_if.slave
//            start/abort/buffer/tok_ready in; tok_valid/token/tok_last/
//            busy/done/count out (all outputs registered)
// ----------------------------------------------------------------------------
module buffer_token_reader (
  input  logic                        clk,
  input  logic                        rst_n,
  buffer_token_reader_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] EMPTY = 4'hF;
  localparam logic [6:0] NSLOT = 7'd96;

  state_t       state_q, state_d;
  logic [0:383] snap_q, snap_d;
  logic [6:0]   idx_q, idx_d;
  logic [6:0]   run_cnt_q, run_cnt_d;
  logic [6:0]   count_q, count_d;
  logic         tok_valid_q, tok_valid_d;
  logic         tok_last_q, tok_last_d;
  logic [3:0]   token_q, token_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Slot view of the snapshot.
  logic [3:0] snap_slot [0:95];

  genvar gi;
  generate
    for (gi = 0; gi < 96; gi++) begin : g_slot
      assign snap_slot[gi] = snap_q[4*gi +: 4];
    end
  endgenerate

  // Slots after the one currently presented. Anything past slot 95 reads as
  // empty so the stream naturally terminates without wrapping.
  logic [6:0] idx_nx1, idx_nx2;
  logic [3:0] slot_nx1, slot_nx2;

  assign idx_nx1  = idx_q + 7'd1;
  assign idx_nx2  = idx_q + 7'd2;
  assign slot_nx1 = (idx_nx1 < NSLOT) ? snap_slot[idx_nx1] : EMPTY;
  assign slot_nx2 = (idx_nx2 < NSLOT) ? snap_slot[idx_nx2] : EMPTY;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    count_d     = count_q;
    tok_valid_d = tok_valid_q;
    tok_last_d  = tok_last_q;
    token_d     = token_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tok_valid_d = 1'b0;
        tok_last_d  = 1'b0;
        if (bus.start) begin
          // The first token is taken straight from the live buffer so that
          // tok_valid is already up on the cycle after start.
          snap_d      = bus.buffer;
          idx_d       = 7'd0;
          run_cnt_d   = 7'd0;
          state_d     = EMIT;
          token_d     = bus.buffer[0:3];
          tok_valid_d = (bus.buffer[0:3] != EMPTY);
          tok_last_d  = (bus.buffer[0:3] != EMPTY) && (bus.buffer[4:7] == EMPTY);
        end
      end

      EMIT: begin
        if (bus.abort) begin
          // Abort wins over a transfer happening on the same edge.
          state_d     = IDLE;
          tok_valid_d = 1'b0;
          tok_last_d  = 1'b0;
        end else if (!tok_valid_q) begin
          // Nothing presentable (empty slot 0): wrap up immediately.
          state_d = FINISH;
        end else if (bus.tok_ready) begin
          idx_d     = idx_nx1;
          run_cnt_d = run_cnt_q + 7'd1;
          if (tok_last_q) begin
            state_d     = FINISH;
            tok_valid_d = 1'b0;
            tok_last_d  = 1'b0;
          end else begin
            // tok_last was low, so the next slot is known to be non-empty
            // and below 96.
            tok_valid_d = 1'b1;
            token_d     = slot_nx1;
            tok_last_d  = (idx_nx1 == NSLOT - 7'd1) || (slot_nx2 == EMPTY);
          end
        end
      end

      FINISH: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        count_d     = run_cnt_q;
        tok_valid_d = 1'b0;
        tok_last_d  = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        tok_valid_d = 1'b0;
        tok_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snap_q      <= '1;
      idx_q       <= 7'd0;
      run_cnt_q   <= 7'd0;
      count_q     <= 7'd0;
      tok_valid_q <= 1'b0;
      tok_last_q  <= 1'b0;
      token_q     <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
      count_q     <= count_d;
      tok_valid_q <= tok_valid_d;
      tok_last_q  <= tok_last_d;
      token_q     <= token_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tok_valid = tok_valid_q;
  assign bus.token     = token_q;
  assign bus.tok_last  = tok_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_buffer_token_reader.sv
// ----------------------------------------------------------------------------
// tb_buffer_token_reader
//   Directed bench for buffer_token_reader. Each scenario task drives its own
//   stimulus and compares against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_buffer_token_reader;

  logic clk;
  logic rst_n;

  buffer_token_reader_if bus();

  buffer_token_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  // Results of the most recent drain() call.
  int         n_xfer;
  logic [3:0] got_tok  [0:127];
  logic       got_last [0:127];
  int         got_hold [0:127];
  int         got_cyc  [0:127];
  int         unstable;
  int         valid_cycles;
  int         done_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Buffer with the first n slots taken from v (slot 0 in v[19:16]), rest 0xF.
  function automatic logic [0:383] mk_buf(input int n, input logic [19:0] v);
    logic [0:383] r;
    r = '1;
    for (int k = 0; k < n; k++) r[4*k +: 4] = v[19-4*k -: 4];
    return r;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Consumes the token stream; holds tok_ready low for 'stall' cycles on each
  // new token. Cycle c=0 is the sample point right after the start edge.
  task automatic drain(input int stall, input int budget, input int chg_at, input int start_at);
    int         wait_left;
    int         hold;
    logic [3:0] htok;
    logic       hlast;
    logic       presenting;
    n_xfer = 0; unstable = 0; valid_cycles = 0; done_at = -1;
    presenting = 1'b0; wait_left = stall; hold = 0; htok = 4'h0; hlast = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.start = (c == start_at);
      if (c == chg_at) bus.buffer = {96{4'h1}};
      if (bus.done === 1'b1) begin
        done_at = c;
        break;
      end
      if (bus.tok_valid === 1'b1) begin
        valid_cycles++;
        if (!presenting) begin
          presenting = 1'b1; htok = bus.token; hlast = bus.tok_last;
          hold = 0; wait_left = stall;
        end else if (bus.token !== htok || bus.tok_last !== hlast) begin
          unstable++;
        end
        hold++;
        if (wait_left == 0) begin
          bus.tok_ready = 1'b1;
          if (n_xfer < 128) begin
            got_tok[n_xfer] = htok; got_last[n_xfer] = hlast;
            got_hold[n_xfer] = hold; got_cyc[n_xfer] = c;
          end
          n_xfer++;
          presenting = 1'b0;
        end else begin
          bus.tok_ready = 1'b0;
          wait_left--;
        end
      end else begin
        if (presenting) unstable++;
        presenting = 1'b0;
        bus.tok_ready = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.tok_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.tok_ready = 1'b0; bus.buffer = '1;
    #12;
    vec_cnt++; if (bus.tok_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_tok_valid: got %b expected 0", bus.tok_valid); end
    vec_cnt++; if (bus.tok_last !== 1'b0) begin err_cnt++; $display("FAIL reset_tok_last: got %b expected 0", bus.tok_last); end
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vec_cnt++; if (bus.token !== 4'h0) begin err_cnt++; $display("FAIL reset_token: got %h expected 0", bus.token); end
    vec_cnt++; if (bus.count !== 7'd0) begin err_cnt++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    rst_n = 1'b1;
    tick(); tick();
    vec_cnt++; if (bus.busy !== 1'b0 || bus.tok_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_no_start: busy %b tok_valid %b expected 0 0", bus.busy, bus.tok_valid); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_tok [0:3];
    exp_tok[0] = 4'h1; exp_tok[1] = 4'h2; exp_tok[2] = 4'hA; exp_tok[3] = 4'h3;
    bus.buffer = mk_buf(4, 20'h12A30);
    do_start();
    vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    vec_cnt++; if (bus.tok_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_latency: tok_valid %b expected 1", bus.tok_valid); end
    drain(0, 30, -1, -1);
    vec_cnt++; if (n_xfer != 4) begin err_cnt++; $display("FAIL basic_nxfer: got %0d expected 4", n_xfer); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (got_tok[i] !== exp_tok[i]) begin err_cnt++; $display("FAIL basic_tok%0d: got %h expected %h", i, got_tok[i], exp_tok[i]); end
      vec_cnt++; if (got_last[i] !== (i == 3)) begin err_cnt++; $display("FAIL basic_last%0d: got %b expected %b", i, got_last[i], (i == 3)); end
      vec_cnt++; if (got_cyc[i] != i) begin err_cnt++; $display("FAIL basic_cyc%0d: got %0d expected %0d", i, got_cyc[i], i); end
    end
    vec_cnt++; if (done_at != 5) begin err_cnt++; $display("FAIL basic_done_at: got %0d expected 5", done_at); end
    vec_cnt++; if (bus.count !== 7'd4) begin err_cnt++; $display("FAIL basic_count: got %0d expected 4", bus.count); end
    tick();
    vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_empty();
    bus.buffer = '1;
    do_start();
    vec_cnt++; if (bus.count !== 7'd4) begin err_cnt++; $display("FAIL empty_count_hold: got %0d expected 4", bus.count); end
    drain(0, 20, -1, -1);
    vec_cnt++; if (valid_cycles != 0) begin err_cnt++; $display("FAIL empty_valid: got %0d valid cycles expected 0", valid_cycles); end
    vec_cnt++; if (done_at != 2) begin err_cnt++; $display("FAIL empty_done_at: got %0d expected 2", done_at); end
    vec_cnt++; if (bus.count !== 7'd0) begin err_cnt++; $display("FAIL empty_count: got %0d expected 0", bus.count); end
    tick();
  endtask

  task automatic test_full();
    int last_sum;
    logic [0:383] b;
    for (int k = 0; k < 96; k++) b[4*k +: 4] = 4'h5;
    bus.buffer = b;
    do_start();
    drain(0, 200, -1, -1);
    vec_cnt++; if (n_xfer != 96) begin err_cnt++; $display("FAIL full_nxfer: got %0d expected 96", n_xfer); end
    last_sum = 0;
    for (int i = 0; i < 96; i++) begin
      vec_cnt++; if (got_tok[i] !== 4'h5) begin err_cnt++; $display("FAIL full_tok%0d: got %h expected 5", i, got_tok[i]); end
      if (got_last[i] === 1'b1) last_sum++;
    end
    vec_cnt++; if (last_sum != 1 || got_last[95] !== 1'b1) begin err_cnt++; $display("FAIL full_last: got %0d lasts, slot95 %b expected 1 1", last_sum, got_last[95]); end
    vec_cnt++; if (done_at != 97) begin err_cnt++; $display("FAIL full_done_at: got %0d expected 97", done_at); end
    vec_cnt++; if (bus.count !== 7'h60) begin err_cnt++; $display("FAIL full_count: got %0d expected 96", bus.count); end
    tick();
    vec_cnt++; if (bus.tok_valid !== 1'b0 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL full_nowrap: tok_valid %b busy %b expected 0 0", bus.tok_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_tok [0:2];
    exp_tok[0] = 4'h7; exp_tok[1] = 4'hB; exp_tok[2] = 4'h9;
    bus.buffer = mk_buf(3, 20'h7B900);
    do_start();
    drain(3, 40, -1, -1);
    vec_cnt++; if (n_xfer != 3) begin err_cnt++; $display("FAIL bp_nxfer: got %0d expected 3", n_xfer); end
    vec_cnt++; if (unstable != 0) begin err_cnt++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (got_tok[i] !== exp_tok[i]) begin err_cnt++; $display("FAIL bp_tok%0d: got %h expected %h", i, got_tok[i], exp_tok[i]); end
      vec_cnt++; if (got_hold[i] != 4) begin err_cnt++; $display("FAIL bp_hold%0d: got %0d expected 4", i, got_hold[i]); end
      vec_cnt++; if (got_last[i] !== (i == 2)) begin err_cnt++; $display("FAIL bp_last%0d: got %b expected %b", i, got_last[i], (i == 2)); end
    end
    vec_cnt++; if (done_at != 13) begin err_cnt++; $display("FAIL bp_done_at: got %0d expected 13", done_at); end
    vec_cnt++; if (bus.count !== 7'd3) begin err_cnt++; $display("FAIL bp_count: got %0d expected 3", bus.count); end
    tick();
  endtask

  task automatic test_snapshot();
    logic [3:0] exp_tok [0:4];
    exp_tok[0] = 4'h4; exp_tok[1] = 4'h0; exp_tok[2] = 4'h6; exp_tok[3] = 4'h8; exp_tok[4] = 4'hC;
    bus.buffer = mk_buf(5, 20'h4068C);
    do_start();
    drain(0, 30, 0, 1);
    vec_cnt++; if (n_xfer != 5) begin err_cnt++; $display("FAIL snap_nxfer: got %0d expected 5", n_xfer); end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (got_tok[i] !== exp_tok[i]) begin err_cnt++; $display("FAIL snap_tok%0d: got %h expected %h", i, got_tok[i], exp_tok[i]); end
    end
    vec_cnt++; if (done_at != 6) begin err_cnt++; $display("FAIL snap_done_at: got %0d expected 6", done_at); end
    vec_cnt++; if (bus.count !== 7'd5) begin err_cnt++; $display("FAIL snap_count: got %0d expected 5", bus.count); end
    tick();
    vec_cnt++; if (bus.busy !== 1'b0 || bus.tok_valid !== 1'b0) begin err_cnt++; $display("FAIL snap_busy_start: busy %b tok_valid %b expected 0 0", bus.busy, bus.tok_valid); end
  endtask

  task automatic test_abort();
    int done_seen;
    bus.buffer = mk_buf(4, 20'h12340);
    do_start();
    vec_cnt++; if (bus.token !== 4'h1 || bus.tok_valid !== 1'b1) begin err_cnt++; $display("FAIL abort_first: token %h valid %b expected 1 1", bus.token, bus.tok_valid); end
    bus.tok_ready = 1'b1;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0; bus.tok_ready = 1'b0;
    vec_cnt++; if (bus.tok_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_valid: got %b expected 0", bus.tok_valid); end
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    vec_cnt++; if (done_seen != 0) begin err_cnt++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
    vec_cnt++; if (bus.count !== 7'd5) begin err_cnt++; $display("FAIL abort_count: got %0d expected 5", bus.count); end
    do_start();
    vec_cnt++; if (bus.token !== 4'h1) begin err_cnt++; $display("FAIL abort_restart_tok: got %h expected 1", bus.token); end
    drain(0, 30, -1, -1);
    vec_cnt++; if (n_xfer != 4 || done_at != 5) begin err_cnt++; $display("FAIL abort_rerun: got %0d xfers done_at %0d expected 4 5", n_xfer, done_at); end
    vec_cnt++; if (bus.count !== 7'd4) begin err_cnt++; $display("FAIL abort_rerun_count: got %0d expected 4", bus.count); end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.buffer = mk_buf(4, 20'h12340);
    do_start();
    bus.tok_ready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.tok_valid !== 1'b0 || bus.tok_last !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valid: valid %b last %b expected 0 0", bus.tok_valid, bus.tok_last); end
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    vec_cnt++; if (bus.token !== 4'h0) begin err_cnt++; $display("FAIL rstmid_token: got %h expected 0", bus.token); end
    vec_cnt++; if (bus.count !== 7'd0) begin err_cnt++; $display("FAIL rstmid_count: got %0d expected 0", bus.count); end
    bus.tok_ready = 1'b0;
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL rstmid_idle: got %0d bad cycles expected 0", bad); end
    do_start();
    vec_cnt++; if (bus.token !== 4'h1 || bus.tok_valid !== 1'b1) begin err_cnt++; $display("FAIL rstmid_restart: token %h valid %b expected 1 1", bus.token, bus.tok_valid); end
    drain(0, 30, -1, -1);
    vec_cnt++; if (n_xfer != 4 || got_tok[3] !== 4'h4) begin err_cnt++; $display("FAIL rstmid_rerun: got %0d xfers last tok %h expected 4 4", n_xfer, got_tok[3]); end
    vec_cnt++; if (bus.count !== 7'd4) begin err_cnt++; $display("FAIL rstmid_count_after: got %0d expected 4", bus.count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
